// File: rtl/toggle_event_monitor.sv
// toggle_event_monitor: per-bit synchronised, glitch-filtered toggle detector with sticky flags and saturating event count
module toggle_event_monitor #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     signal,
  input  logic [1:0]           edge_mode,
  input  logic                 clear,
  output logic [WIDTH-1:0]     toggle_vec,
  output logic                 toggle_flag,
  output logic [WIDTH-1:0]     sticky_vec,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 count_sat
);
  // One capture flop ahead of the synchroniser flops gives the filter a registered sample,
  // so a toggle pulse appears SYNC_STAGES + 1 + FILTER_CYCLES edges after the input change.
  localparam int NS = SYNC_STAGES + 1;
  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [3:0] FC = 4'(FILTER_CYCLES);
  logic [NS-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s, f_q, f_d, toggle_q, toggle_d, sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic count_sat_q, count_sat_d;
  logic [CNT_WIDTH:0] pc, sum;
  assign s = sync_q[NS-1];
  // Shift the sampled input down the synchroniser chain.
  always_comb begin
    sync_d[0] = signal;
    for (int i = 1; i < NS; i++) sync_d[i] = sync_q[i-1];
  end
  // Per-bit filter: accept a new level only after it has been stable long enough; flag mode-qualified changes.
  always_comb begin
    cnt_d = '0;
    f_d = f_q;
    toggle_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = (s[i] == f_q[i] || cnt_q[i] == FC) ? 4'd0 : cnt_q[i] + 4'd1;
      f_d[i] = (s[i] != f_q[i] && cnt_q[i] == FC) ? s[i] : f_q[i];
      toggle_d[i] = (f_d[i] != f_q[i]) &&
                    (edge_mode == 2'b00 || (edge_mode == 2'b01 && f_d[i]) || (edge_mode == 2'b10 && !f_d[i]));
    end
  end
  // Accumulate pulses into sticky flags and a saturating counter; clear takes priority.
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CW1'(toggle_q[i]);
    sum = {1'b0, count_q} + pc;
    count_d = clear ? '0 : sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    sticky_d = clear ? '0 : sticky_q | toggle_q;
    count_sat_d = &count_d;
  end
  // State registers, cleared immediately when reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      f_q <= '0;
      toggle_q <= '0;
      sticky_q <= '0;
      count_q <= '0;
      count_sat_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      f_q <= f_d;
      toggle_q <= toggle_d;
      sticky_q <= sticky_d;
      count_q <= count_d;
      count_sat_q <= count_sat_d;
    end
  end
  assign toggle_vec = toggle_q;
  assign toggle_flag = |toggle_q;
  assign sticky_vec = sticky_q;
  assign event_count = count_q;
  assign count_sat = count_sat_q;
endmodule

// File: tb/tb_toggle_event_monitor.sv
// tb_toggle_event_monitor: directed checks of timing, edge modes, filtering, saturation, clear and reset
module tb_toggle_event_monitor;
  logic clk, reset, clear;
  logic [1:0] edge_mode;
  logic [7:0] sig0, sig1, sig2;
  logic [7:0] tv0, st0, tv1, st1, tv2, st2;
  logic tf0, tf1, tf2, sat0, sat1, sat2;
  logic [15:0] cnt0, cnt1;
  logic [3:0] cnt2;
  int n_tests, n_fail;
  toggle_event_monitor u0 (.clk(clk), .reset(reset), .signal(sig0), .edge_mode(edge_mode), .clear(clear),
    .toggle_vec(tv0), .toggle_flag(tf0), .sticky_vec(st0), .event_count(cnt0), .count_sat(sat0));
  toggle_event_monitor #(.FILTER_CYCLES(3)) u1 (.clk(clk), .reset(reset), .signal(sig1), .edge_mode(edge_mode),
    .clear(clear), .toggle_vec(tv1), .toggle_flag(tf1), .sticky_vec(st1), .event_count(cnt1), .count_sat(sat1));
  toggle_event_monitor #(.CNT_WIDTH(4)) u2 (.clk(clk), .reset(reset), .signal(sig2), .edge_mode(edge_mode),
    .clear(clear), .toggle_vec(tv2), .toggle_flag(tf2), .sticky_vec(st2), .event_count(cnt2), .count_sat(sat2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    clear = 1'b0;
    edge_mode = 2'b00;
    sig0 = '0;
    sig1 = '0;
    sig2 = '0;
    #2;
    check("rst_toggle", tv0, 8'h00);
    check("rst_count", cnt0, 16'd0);
    tick(2);
    reset = 1'b1;
    tick(3);
    check("idle_toggle", tv0, 8'h00);
    check("idle_sticky", st0, 8'h00);
    check("idle_sat", sat0, 1'b0);
    // latency: change sampled at edge 0, pulse at edge 3, accumulate at edge 4
    sig0 = 8'h01;
    tick(3);
    check("t1_e2_toggle", tv0, 8'h00);
    tick(1);
    check("t1_e3_toggle", tv0, 8'h01);
    check("t1_e3_flag", tf0, 1'b1);
    check("t1_e3_count", cnt0, 16'd0);
    tick(1);
    check("t1_e4_toggle", tv0, 8'h00);
    check("t1_e4_sticky", st0, 8'h01);
    check("t1_e4_count", cnt0, 16'd1);
    // rising-only, falling-only and disabled modes
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t2_clear", cnt0, 16'd0);
    edge_mode = 2'b01;
    sig0 = 8'h00;
    tick(10);
    sig0 = 8'h01;
    tick(10);
    sig0 = 8'h00;
    tick(10);
    check("t2_rise_count", cnt0, 16'd1);
    check("t2_rise_sticky", st0, 8'h01);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    edge_mode = 2'b10;
    sig0 = 8'h01;
    tick(10);
    sig0 = 8'h00;
    tick(10);
    check("t2_fall_count", cnt0, 16'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    edge_mode = 2'b11;
    sig0 = 8'h01;
    tick(10);
    sig0 = 8'h00;
    tick(10);
    check("t2_off_count", cnt0, 16'd0);
    check("t2_off_sticky", st0, 8'h00);
    edge_mode = 2'b00;
    // all bits toggle together
    sig0 = 8'hFF;
    tick(4);
    check("t4_toggle", tv0, 8'hFF);
    check("t4_flag", tf0, 1'b1);
    tick(1);
    check("t4_flag_off", tf0, 1'b0);
    check("t4_count", cnt0, 16'd8);
    check("t4_sticky", st0, 8'hFF);
    // glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted at latency 6
    sig1 = 8'h04;
    tick(3);
    sig1 = 8'h00;
    tick(12);
    check("t3_glitch_count", cnt1, 16'd0);
    check("t3_glitch_sticky", st1, 8'h00);
    sig1 = 8'h04;
    tick(4);
    sig1 = 8'h00;
    tick(2);
    check("t3_e5_toggle", tv1, 8'h00);
    tick(1);
    check("t3_e6_toggle", tv1, 8'h04);
    tick(1);
    check("t3_e7_count", cnt1, 16'd1);
    tick(10);
    check("t3_fall_count", cnt1, 16'd2);
    // saturation with a 4-bit counter
    sig2 = 8'hFF;
    tick(6);
    sig2 = 8'hE0;
    tick(6);
    check("t5_pre_count", cnt2, 4'd13);
    check("t5_pre_sat", sat2, 1'b0);
    sig2 = 8'hE7;
    tick(4);
    check("t5_toggle", tv2, 8'h07);
    tick(1);
    check("t5_sat_count", cnt2, 4'd15);
    check("t5_sat", sat2, 1'b1);
    sig2 = 8'h00;
    tick(6);
    check("t5_hold_count", cnt2, 4'd15);
    check("t5_hold_sat", sat2, 1'b1);
    // clear coincident with a pulse wins
    sig0 = 8'h00;
    tick(4);
    check("t6_toggle", tv0, 8'hFF);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t6_clr_count", cnt0, 16'd0);
    check("t6_clr_sticky", st0, 8'h00);
    check("t6_clr_cnt2", cnt2, 4'd0);
    check("t6_clr_sat2", sat2, 1'b0);
    tick(1);
    check("t6_after_count", cnt0, 16'd0);
    // asynchronous reset in the middle of a pulse
    sig0 = 8'hAA;
    tick(5);
    sig0 = 8'h00;
    tick(4);
    check("t6_pre_toggle", tv0, 8'hAA);
    check("t6_pre_count", cnt0, 16'd4);
    check("t6_pre_sticky", st0, 8'hAA);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_toggle", tv0, 8'h00);
    check("t6_rst_flag", tf0, 1'b0);
    check("t6_rst_sticky", st0, 8'h00);
    check("t6_rst_count", cnt0, 16'd0);
    check("t6_rst_cnt1", cnt1, 16'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
